// File: rtl/axi_fetch_unit.sv
// axi_fetch_unit: instruction fetch front end. Issues aligned line-sized INCR
// bursts on AXI AR, splits R beats into 32-bit instructions, and queues
// {inst, pc} for decode. A redirect flushes the queue and discards any burst
// that is still in flight.

// One instruction slot of a beat: decides whether the slot is kept and what its PC is.
module axi_fetch_lane #(
  parameter int ADDR_WIDTH = 64,
  parameter int IDX_W      = 4,
  parameter int BEAT_W     = 3,
  parameter int IPB        = 2,
  parameter int LANE       = 0
) (
  input  logic [BEAT_W-1:0]     beat,
  input  logic [IDX_W-1:0]      skip,
  input  logic [ADDR_WIDTH-1:0] line_base,
  input  logic                  beat_ok,
  output logic                  keep,
  output logic [ADDR_WIDTH-1:0] pc
);
  logic [IDX_W-1:0] idx;

  assign idx  = IDX_W'(beat) * IDX_W'(IPB) + IDX_W'(LANE);
  // Slots ahead of the fetch PC within the first line are dropped.
  assign keep = beat_ok && (idx >= skip);
  assign pc   = line_base + ADDR_WIDTH'({idx, 2'b00});
endmodule

module axi_fetch_unit #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] entry,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  fetch_err,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  localparam int IPB     = DATA_WIDTH / 32;
  localparam int LINE    = BURST_LEN * DATA_WIDTH / 8;
  localparam int LINE_LG = $clog2(LINE);
  localparam int IDX_W   = LINE_LG - 2;
  localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int PTR_W   = AW + 1;
  localparam int NEED    = BURST_LEN * IPB;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE - 1);

  typedef enum logic [1:0] {IDLE, AR, R, DRAIN} state_t;

  state_t                       state, nstate;
  logic [ADDR_WIDTH-1:0]        fetch_pc, ar_addr;
  logic [IDX_W-1:0]             skip;
  logic [BEAT_W-1:0]            beat;
  logic                         kill;
  logic [PTR_W-1:0]             rd_ptr, wr_ptr, count, free, push_cnt;
  logic [PTR_W-1:0]             slot_off [IPB];
  logic [31:0]                  inst_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]        pc_mem   [FIFO_DEPTH];
  logic [IPB-1:0]               keep;
  logic [IPB-1:0][ADDR_WIDTH-1:0] lane_pc;
  logic [IPB-1:0][31:0]         lane_inst;
  logic                         ar_hs, r_hs, r_ok, beat_ok, pop;

  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = 2'b01;
  assign m_axi_araddr  = ar_addr;
  assign m_axi_arvalid = (state == AR);
  assign m_axi_rready  = (state == R) || (state == DRAIN);

  assign ar_hs   = m_axi_arvalid && m_axi_arready;
  assign r_hs    = m_axi_rvalid && m_axi_rready;
  assign r_ok    = (m_axi_rresp == 2'b00);
  assign beat_ok = (state == R) && r_hs && r_ok && !redirect_valid;

  assign count     = wr_ptr - rd_ptr;
  assign free      = PTR_W'(FIFO_DEPTH) - count;
  assign out_valid = (count != '0);
  assign out_inst  = inst_mem[rd_ptr[AW-1:0]];
  assign out_pc    = pc_mem[rd_ptr[AW-1:0]];
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign lane_inst = m_axi_rdata;

  for (genvar k = 0; k < IPB; k++) begin : g_lane
    axi_fetch_lane #(
      .ADDR_WIDTH(ADDR_WIDTH), .IDX_W(IDX_W), .BEAT_W(BEAT_W), .IPB(IPB), .LANE(k)
    ) u_lane (
      .beat(beat), .skip(skip), .line_base(ar_addr), .beat_ok(beat_ok),
      .keep(keep[k]), .pc(lane_pc[k])
    );
  end

  // Next state: a request only starts when a whole burst fits, so R never stalls.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (!redirect_valid && !fetch_err && free >= PTR_W'(NEED)) nstate = AR;
      AR:    if (ar_hs) nstate = (kill || redirect_valid) ? DRAIN : R;
      R:     if (r_hs && m_axi_rlast) nstate = IDLE;
             else if (redirect_valid || (r_hs && !r_ok)) nstate = DRAIN;
      DRAIN: if (r_hs && m_axi_rlast) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Fetch control: request address, skip offset, beat count, error and PC tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= entry;
      ar_addr   <= '0;
      skip      <= '0;
      beat      <= '0;
      kill      <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state <= nstate;
      // araddr is latched so a redirect cannot disturb a pending request.
      if (state == IDLE && nstate == AR) begin
        ar_addr <= fetch_pc & ~LINE_MASK;
        kill    <= 1'b0;
      end
      if (state == AR && redirect_valid) kill <= 1'b1;
      if (ar_hs) begin
        skip <= fetch_pc[LINE_LG-1:2];
        beat <= '0;
      end
      if (state == R && r_hs) beat <= beat + BEAT_W'(1);
      if (state == R && r_hs && !r_ok) fetch_err <= 1'b1;
      if (redirect_valid) fetch_pc <= redirect_pc;
      else if (state == R && r_hs && m_axi_rlast && r_ok) fetch_pc <= ar_addr + ADDR_WIDTH'(LINE);
    end
  end

  // Pack kept slots of a beat into consecutive FIFO entries.
  always_comb begin
    push_cnt = '0;
    for (int k = 0; k < IPB; k++) begin
      slot_off[k] = push_cnt;
      if (keep[k]) push_cnt = push_cnt + PTR_W'(1);
    end
  end

  // FIFO pointers: redirect flushes by snapping read to write.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      wr_ptr <= wr_ptr + push_cnt;
    end
  end

  // FIFO storage writes, up to IPB entries per cycle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < IPB; k++) begin
      if (keep[k]) begin
        inst_mem[AW'(wr_ptr + slot_off[k])] <= lane_inst[k];
        pc_mem[AW'(wr_ptr + slot_off[k])]   <= lane_pc[k];
      end
    end
  end
endmodule

// File: tb/tb_axi_fetch_unit.sv
// tb_axi_fetch_unit: directed bench with a zero-wait AXI slave model and
// a table of fetch scenarios plus hand sequences for backpressure/redirect.
module tb_axi_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, redirect_valid, out_ready, out_valid, fetch_err;
  logic [63:0] entry, redirect_pc, out_pc, araddr;
  logic [31:0] out_inst;
  logic [12:0] arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [63:0] rdata;

  axi_fetch_unit dut (
    .clk(clk), .reset(reset), .entry(entry), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .fetch_err(fetch_err),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int ar_stall = 0, stall_cnt = 0, err_beat = 8, sbeat = 0, r_total = 0, proto_bad = 0;
  bit busy = 0;
  logic [63:0] sbase;
  logic [63:0] ar_log[$];
  int          ar_pops[$], ar_rtot[$];
  logic [63:0] got_pc[$];
  logic [31:0] got_inst[$];
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic [12:0] s_arid;

  function automatic logic [31:0] f(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave: samples handshakes mid-cycle, updates its outputs just after the edge.
  initial begin
    bit ar_hs, r_hs;
    logic [63:0] hs_addr, a;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0;
    forever begin
      @(negedge clk); #2;
      ar_hs = arvalid && arready; r_hs = rvalid && rready; hs_addr = araddr;
      @(posedge clk); #1;
      if (reset) begin
        busy = 0; arready = 0; rvalid = 0; rlast = 0; stall_cnt = ar_stall;
      end else begin
        if (r_hs) begin
          if (rlast) busy = 0; else sbeat++;
        end
        if (ar_hs) begin
          busy = 1; sbase = hs_addr; sbeat = 0; arready = 0; stall_cnt = ar_stall;
        end else if (arvalid && !arready && !busy) begin
          if (stall_cnt == 0) arready = 1; else stall_cnt--;
        end
        a      = sbase + 64'(8 * sbeat);
        rvalid = busy;
        rlast  = busy && (sbeat == 7);
        rdata  = {f(a + 64'd4), f(a)};
        rresp  = (busy && sbeat == err_beat) ? 2'b10 : 2'b00;
      end
    end
  end

  // Monitor: AR log, R beat count, delivered instructions, AR stability.
  initial begin
    bit ar_pend = 0;
    logic [63:0] pend_addr = '0;
    forever begin
      @(negedge clk); #2;
      if (!reset) begin
        if (arvalid && busy) proto_bad++;
        if (ar_pend && (!arvalid || araddr !== pend_addr)) proto_bad++;
        ar_pend = arvalid && !arready; pend_addr = araddr;
        if (arvalid && arready) begin
          ar_log.push_back(araddr); ar_pops.push_back(got_pc.size()); ar_rtot.push_back(r_total);
          s_arlen = arlen; s_arsize = arsize; s_arburst = arburst; s_arid = arid;
        end
        if (rvalid && rready) r_total++;
        if (out_valid && out_ready && !redirect_valid) begin
          got_pc.push_back(out_pc); got_inst.push_back(out_inst);
        end
      end else ar_pend = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic [63:0] e);
    reset = 1; entry = e; redirect_valid = 0; redirect_pc = '0;
    repeat (3) @(negedge clk);
    ar_log.delete(); ar_pops.delete(); ar_rtot.delete();
    got_pc.delete(); got_inst.delete(); r_total = 0;
    reset = 0;
  endtask

  task automatic wait_ar(input int n, input string name);
    for (int c = 0; c < 400 && ar_log.size() < n; c++) @(negedge clk);
    chk(name, ar_log.size() >= n, 1);
  endtask

  function automatic int count_range(input logic [63:0] lo, input logic [63:0] len);
    int n = 0;
    foreach (got_pc[i]) if (got_pc[i] - lo < len) n++;
    return n;
  endfunction

  typedef struct {
    logic [63:0] entry;
    int          err_beat;
    int          n_ar;
    logic [63:0] ar0, ar1, pc0;
    int          seq_len, line_cnt;
    logic        err;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int bad, mark;
    vecs[0] = '{64'h1000, 8, 2, 64'h1000, 64'h1040, 64'h1000, 16, 16, 1'b0};
    vecs[1] = '{64'h1014, 8, 2, 64'h1000, 64'h1040, 64'h1014, 11, 11, 1'b0};
    vecs[2] = '{64'h2FF8, 8, 2, 64'h2FC0, 64'h3000, 64'h2FF8,  2,  2, 1'b0};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFF0, 8, 2, 64'hFFFF_FFFF_FFFF_FFC0, 64'h0,
                64'hFFFF_FFFF_FFFF_FFF0, 4, 4, 1'b0};
    vecs[4] = '{64'h1000, 2, 1, 64'h1000, 64'h0, 64'h1000, 4, -1, 1'b1};

    out_ready = 1;
    do_reset(64'h1000);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fetch_err", fetch_err, 0);

    // Scenario table: entry alignment, line end, address wrap, error burst.
    foreach (vecs[v]) begin
      err_beat = vecs[v].err_beat; ar_stall = 0; out_ready = 1;
      do_reset(vecs[v].entry);
      for (int c = 0; c < 400 && ar_log.size() < vecs[v].n_ar; c++) @(negedge clk);
      repeat (60) @(negedge clk);
      chk($sformatf("v%0d_ar_cnt", v), (ar_log.size() >= 2) ? 2 : ar_log.size(), vecs[v].n_ar);
      chk($sformatf("v%0d_ar0", v), ar_log.size() > 0 ? ar_log[0] : 'x, vecs[v].ar0);
      if (vecs[v].n_ar == 2)
        chk($sformatf("v%0d_ar1", v), ar_log.size() > 1 ? ar_log[1] : 'x, vecs[v].ar1);
      chk($sformatf("v%0d_pc0", v), got_pc.size() > 0 ? got_pc[0] : 'x, vecs[v].pc0);
      bad = 0;
      for (int i = 0; i < vecs[v].seq_len; i++)
        if (i >= got_pc.size() || got_pc[i] !== vecs[v].pc0 + 64'(4 * i) ||
            got_inst[i] !== f(got_pc[i])) bad++;
      chk($sformatf("v%0d_seq_bad", v), bad, 0);
      if (vecs[v].line_cnt >= 0)
        chk($sformatf("v%0d_line_cnt", v), count_range(vecs[v].ar0, 64), vecs[v].line_cnt);
      if (vecs[v].err_beat < 8)
        chk($sformatf("v%0d_errbeat_cnt", v),
            count_range(vecs[v].ar0 + 64'(8 * vecs[v].err_beat), 8), 0);
      chk($sformatf("v%0d_fetch_err", v), fetch_err, vecs[v].err);
      if (v == 0) begin
        chk("arlen", s_arlen, 7); chk("arsize", s_arsize, 3);
        chk("arburst", s_arburst, 1); chk("arid", s_arid, 0);
      end
      reset = 1; @(negedge clk);
      chk($sformatf("v%0d_err_cleared", v), fetch_err, 0);
    end
    err_beat = 8;

    // Backpressure: full FIFO, partial drain, then no loss/dup.
    out_ready = 0; do_reset(64'h1000);
    repeat (100) @(negedge clk);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_ar_cnt_full", ar_log.size(), 1);
    out_ready = 1; repeat (4) @(negedge clk); out_ready = 0;
    repeat (50) @(negedge clk);
    chk("bp_ar_cnt_part", ar_log.size(), 1);
    chk("bp_pops_part", got_pc.size(), 4);
    out_ready = 1;
    wait_ar(2, "bp_ar2_timeout");
    chk("bp_pops_at_ar2", ar_pops.size() > 1 ? ar_pops[1] : -1, 16);
    chk("bp_ar2", ar_log.size() > 1 ? ar_log[1] : 'x, 64'h1040);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (i >= got_pc.size() || got_pc[i] !== 64'h1000 + 64'(4 * i) || got_inst[i] !== f(got_pc[i])) bad++;
    chk("bp_seq_bad", bad, 0);

    // Redirect on the third R beat.
    out_ready = 1; do_reset(64'h1000);
    for (int c = 0; c < 200 && !(rvalid && sbeat == 2); c++) @(negedge clk);
    chk("rd_beat2_seen", rvalid && sbeat == 2, 1);
    redirect_valid = 1; redirect_pc = 64'h2008; mark = got_pc.size();
    @(negedge clk); redirect_valid = 0;
    wait_ar(2, "rd_ar2_timeout");
    chk("rd_ar2", ar_log.size() > 1 ? ar_log[1] : 'x, 64'h2000);
    chk("rd_beats_drained", ar_rtot.size() > 1 ? ar_rtot[1] : -1, 8);
    for (int c = 0; c < 100 && got_pc.size() <= mark; c++) @(negedge clk);
    chk("rd_first_pc", got_pc.size() > mark ? got_pc[mark] : 'x, 64'h2008);
    chk("rd_stale_cnt", count_range(64'h1010, 64'h2000 - 64'h1010), 0);

    // Redirect while AR is stalled.
    ar_stall = 6; out_ready = 1; do_reset(64'h1000);
    for (int c = 0; c < 50 && !arvalid; c++) @(negedge clk);
    chk("ars_arvalid", arvalid && !arready, 1);
    redirect_valid = 1; redirect_pc = 64'h3004;
    @(negedge clk); redirect_valid = 0; ar_stall = 0;
    wait_ar(2, "ars_ar2_timeout");
    chk("ars_ar0", ar_log.size() > 0 ? ar_log[0] : 'x, 64'h1000);
    chk("ars_ar1", ar_log.size() > 1 ? ar_log[1] : 'x, 64'h3000);
    chk("ars_beats_drained", ar_rtot.size() > 1 ? ar_rtot[1] : -1, 8);
    for (int c = 0; c < 100 && got_pc.size() == 0; c++) @(negedge clk);
    chk("ars_first_pc", got_pc.size() > 0 ? got_pc[0] : 'x, 64'h3004);
    chk("ars_old_line_cnt", count_range(64'h1000, 64), 0);

    chk("axi_ar_protocol", proto_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
